vai_tx_arb: RTL and testbench
=============================

// Module: vai_tx_arb
// PURPOSE
// Transmit-side counterpart of the VAI Rx demux: merges CCI-P Tx requests from
// NUM_SUB_AFUS sub-AFUs onto one upstream Tx port. Per-AFU, per-channel FIFOs
// absorb bursts. Independent round-robin arbiters drive c0 (reads) and c1
// (writes/fences). The granted AFU index is stamped into the top mdata bits, so
// upstream Rx responses can be demuxed back by tag.
// PARAMETERS
// NUM_SUB_AFUS  4   number of sub-AFU Tx ports (2..16)
// FIFO_DEPTH    16  entries per AFU per channel (power of 2)
// ALMFULL_THR   8   occupancy at which afu_cXAlmFull asserts
// ID_W          $clog2(NUM_SUB_AFUS)  tag width (derived, do not override)
// PORTS
// pClk             in   1                 clock
// SoftReset_n      in   1                 async active-low reset
// afu_TxPort       in   t_if_ccip_Tx [N]  sub-AFU requests (c0, c1; c2 ignored)
// afu_c0AlmFull    out  N                 per-AFU c0 backpressure
// afu_c1AlmFull    out  N                 per-AFU c1 backpressure
// up_c0TxAlmFull   in   1                 upstream c0 backpressure
// up_c1TxAlmFull   in   1                 upstream c1 backpressure
// up_TxPort        out  t_if_ccip_Tx      merged upstream requests; c2 tied 0
// err_overflow     out  N                 sticky: push into a full FIFO
// BEHAVIOUR
// Reset (async assert, sync release): all FIFOs empty, RR pointers=0, c1 lock
//   cleared. up_TxPort all 0 (valids 0). afu_cXAlmFull=0. err_overflow=0.
// Enqueue: afu_TxPort[i].cX.valid pushes hdr+data into FIFO cX[i] the same cycle.
// AlmFull: registered. afu_cXAlmFull[i]=1 the cycle after occupancy>=ALMFULL_THR.
// Overflow: push with FIFO full and no same-cycle pop -> request dropped,
//   err_overflow[i] set until reset. Push+pop on a full FIFO is legal, no drop.
// c0 arbiter: each cycle with up_c0TxAlmFull=0, grant first non-empty FIFO
//   scanning from (last_grant+1) mod N. Pop it. Register it into up_TxPort.c0
//   with valid=1 next cycle. No grant -> valid=0. Pointer moves only on grant.
// c1 arbiter states:
//   IDLE: same RR grant as c0, gated by up_c1TxAlmFull.
//     Granted beat sop=1 with cl_len>0 -> LOCKED, beats_left=cl_len.
//   LOCKED: grant only the locked AFU. Each popped beat decrements beats_left.
//     At beats_left==0 -> IDLE.
//     Locked FIFO empty or up almFull -> stall (valid=0), no other AFU granted.
//   Multi-line writes are never interleaved. WrFence is a single beat.
// Tagging: out hdr.mdata[15:16-ID_W] = granted index; rest of hdr/data verbatim.
//   Sub-AFUs must not rely on those mdata bits.
// Latency: request at cycle t -> earliest up_TxPort valid at t+2.
// Throughput: 1 request per channel per cycle; c0 and c1 independent.
// Reset mid-operation: partial multi-line beats are discarded, not replayed.
// TESTING
// N=4: AFU0..3 each push 1 c0 read at cycle 0, up almFull=0 -> up c0 valid
//   cycles 2,3,4,5; order 0,1,2,3; mdata[15:14]=0,1,2,3.
// AFU1 pushes 4-beat write (cl_len=3) one cycle before AFU2 single write ->
//   AFU1 beats on 4 consecutive cycles, then AFU2 beat.
// up_c0TxAlmFull=1 for 20 cycles, AFU0 pushes 1/cycle while afu_c0AlmFull[0]=0
//   -> no up valid. afu_c0AlmFull[0]=1 from cycle 9. Release -> 8+ reads drain in order.
// AFU0 pushes 17 c0 reads back-to-back, upstream blocked -> err_overflow[0]=1,
//   first 16 delivered after release.
// Reset asserted after 2 of 4 beats of a write -> up valids 0 immediately.
//   After release, no stale beats and lock cleared.
// All 4 AFUs saturate c0 for 400 cycles -> each granted exactly 100 times,
//   strict rotation.

Source files
------------

// File: rtl/vai_tx_arb.sv
// vai_tx_arb: merges CCI-P Tx requests from several sub-AFUs onto one
// upstream Tx port. Per-AFU, per-channel FIFOs absorb bursts, independent
// round-robin arbiters serve c0 (reads) and c1 (writes/fences), and the
// granted AFU index is stamped into the top mdata bits so responses can be
// routed back by tag. Multi-line c1 writes are kept contiguous.

package vai_tx_pkg;
   typedef struct packed {
      logic [1:0]  vc_sel;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      logic [1:0]  vc_sel;
      logic        sop;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      logic [511:0]       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      logic [8:0]  tid;
      logic        mmioRdValid;
      logic [63:0] data;
   } t_if_ccip_c2_Tx;

   typedef struct packed {
      t_if_ccip_c0_Tx c0;
      t_if_ccip_c1_Tx c1;
      t_if_ccip_c2_Tx c2;
   } t_if_ccip_Tx;
endpackage

// Single-clock FIFO with registered almost-full and a sticky overflow flag.
// The head entry is read combinationally so a grant can pop and forward it
// in the same cycle.
module vai_tx_fifo #(
   parameter int W           = 8,
   parameter int DEPTH       = 16,
   parameter int ALMFULL_THR = 8
) (
   input  logic         pClk,
   input  logic         SoftReset_n,
   input  logic         push,
   input  logic [W-1:0] pushData,
   input  logic         pop,
   output logic [W-1:0] headData,
   output logic         notEmpty,
   output logic         almFull,
   output logic         overflow
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [AW:0]   count;
   logic          full, doPush, doPop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign notEmpty = (count != '0);
   // A push into a full FIFO is still accepted when the head leaves this cycle.
   assign doPush   = push && (!full || pop);
   assign doPop    = pop && notEmpty;
   assign headData = mem[rdPtr];

   // Storage write; contents need no reset because occupancy gates every read.
   always_ff @(posedge pClk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

   // Pointers, occupancy, almost-full and overflow bookkeeping.
   always_ff @(posedge pClk or negedge SoftReset_n) begin
      if (!SoftReset_n) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         almFull  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         almFull <= (count >= (AW+1)'(ALMFULL_THR));
         if (push && full && !pop) overflow <= 1'b1;
      end
   end
endmodule

module vai_tx_arb import vai_tx_pkg::*; #(
   parameter int NUM_SUB_AFUS = 4,
   parameter int FIFO_DEPTH   = 16,
   parameter int ALMFULL_THR  = 8
) (
   input  logic                    pClk,
   input  logic                    SoftReset_n,
   input  t_if_ccip_Tx             afu_TxPort [NUM_SUB_AFUS],
   output logic [NUM_SUB_AFUS-1:0] afu_c0AlmFull,
   output logic [NUM_SUB_AFUS-1:0] afu_c1AlmFull,
   input  logic                    up_c0TxAlmFull,
   input  logic                    up_c1TxAlmFull,
   output t_if_ccip_Tx             up_TxPort,
   output logic [NUM_SUB_AFUS-1:0] err_overflow
);
   localparam int ID_W    = $clog2(NUM_SUB_AFUS);
   localparam int C0W     = $bits(t_ccip_c0_ReqMemHdr);
   localparam int C1W     = $bits(t_ccip_c1_ReqMemHdr) + 512;
   localparam int TAG_LSB = 16 - ID_W;
   localparam logic [15:0] TAG_MASK = ~(16'hFFFF >> ID_W);

   typedef enum logic {C1_IDLE, C1_LOCKED} t_c1State;

   logic [NUM_SUB_AFUS-1:0][C0W-1:0] c0Head;
   logic [NUM_SUB_AFUS-1:0][C1W-1:0] c1Head;
   logic [NUM_SUB_AFUS-1:0]          c0NotEmpty, c1NotEmpty;
   logic [NUM_SUB_AFUS-1:0]          c0Pop, c1Pop;
   logic [NUM_SUB_AFUS-1:0]          c0Ovf, c1Ovf;

   // First requester at or after ptr, wrapping; MSB flags that one was found.
   function automatic logic [ID_W:0] rrPick(input logic [ID_W-1:0] ptr,
                                            input logic [NUM_SUB_AFUS-1:0] req);
      logic [ID_W:0] r;
      int idx;
      r = '0;
      for (int k = NUM_SUB_AFUS-1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_SUB_AFUS;
         if (req[idx]) r = {1'b1, ID_W'(idx)};
      end
      return r;
   endfunction

   function automatic logic [ID_W-1:0] nextIdx(input logic [ID_W-1:0] id);
      return (id == ID_W'(NUM_SUB_AFUS-1)) ? '0 : id + 1'b1;
   endfunction

   function automatic logic [15:0] tagMdata(input logic [15:0] m,
                                            input logic [ID_W-1:0] id);
      return (m & ~TAG_MASK) | (16'(id) << TAG_LSB);
   endfunction

   for (genvar i = 0; i < NUM_SUB_AFUS; i++) begin : gLane
      vai_tx_fifo #(.W(C0W), .DEPTH(FIFO_DEPTH), .ALMFULL_THR(ALMFULL_THR)) uC0 (
         .pClk(pClk), .SoftReset_n(SoftReset_n),
         .push(afu_TxPort[i].c0.valid), .pushData(afu_TxPort[i].c0.hdr),
         .pop(c0Pop[i]), .headData(c0Head[i]), .notEmpty(c0NotEmpty[i]),
         .almFull(afu_c0AlmFull[i]), .overflow(c0Ovf[i]));
      vai_tx_fifo #(.W(C1W), .DEPTH(FIFO_DEPTH), .ALMFULL_THR(ALMFULL_THR)) uC1 (
         .pClk(pClk), .SoftReset_n(SoftReset_n),
         .push(afu_TxPort[i].c1.valid),
         .pushData({afu_TxPort[i].c1.hdr, afu_TxPort[i].c1.data}),
         .pop(c1Pop[i]), .headData(c1Head[i]), .notEmpty(c1NotEmpty[i]),
         .almFull(afu_c1AlmFull[i]), .overflow(c1Ovf[i]));
   end

   assign err_overflow = c0Ovf | c1Ovf;

   // ---------------- c0: plain round robin ----------------
   // c0Ptr is the first index scanned (last grant + 1); reset favours AFU0.
   logic [ID_W-1:0]    c0Ptr, c0Gnt;
   logic [ID_W:0]      c0Pick;
   logic               c0Go;
   t_ccip_c0_ReqMemHdr c0HdrSel, c0Tagged;
   t_if_ccip_c0_Tx     c0Out;

   // Pick the next non-empty c0 FIFO and prepare its tagged header.
   always_comb begin
      c0Pick   = rrPick(c0Ptr, c0NotEmpty);
      c0Gnt    = c0Pick[ID_W-1:0];
      c0Go     = c0Pick[ID_W] && !up_c0TxAlmFull;
      c0Pop    = '0;
      if (c0Go) c0Pop[c0Gnt] = 1'b1;
      c0HdrSel = t_ccip_c0_ReqMemHdr'(c0Head[c0Gnt]);
      c0Tagged = c0HdrSel;
      c0Tagged.mdata = tagMdata(c0HdrSel.mdata, c0Gnt);
   end

   // Register the c0 grant onto the upstream port and advance the pointer.
   always_ff @(posedge pClk or negedge SoftReset_n) begin
      if (!SoftReset_n) begin
         c0Ptr <= '0;
         c0Out <= '0;
      end else begin
         if (c0Go) c0Ptr <= nextIdx(c0Gnt);
         c0Out.valid <= c0Go;
         c0Out.hdr   <= c0Go ? c0Tagged : '0;
      end
   end

   // ---------------- c1: round robin with multi-line lock ----------------
   t_c1State           c1State, c1NextState;
   logic [ID_W-1:0]    c1Ptr, c1Gnt, lockId, lockNext;
   logic [ID_W:0]      c1Pick;
   logic               c1Go;
   logic [1:0]         beatsLeft, beatsNext;
   t_ccip_c1_ReqMemHdr c1HdrSel, c1Tagged;
   logic [511:0]       c1DataSel;
   t_if_ccip_c1_Tx     c1Out;

   // Next-state and grant: RR when idle, only the locked AFU mid-burst.
   always_comb begin
      c1NextState = c1State;
      c1Pick      = rrPick(c1Ptr, c1NotEmpty);
      c1Gnt       = c1Pick[ID_W-1:0];
      c1Go        = 1'b0;
      beatsNext   = beatsLeft;
      lockNext    = lockId;
      case (c1State)
         C1_IDLE:   c1Go = c1Pick[ID_W] && !up_c1TxAlmFull;
         C1_LOCKED: begin
            c1Gnt = lockId;
            c1Go  = c1NotEmpty[lockId] && !up_c1TxAlmFull;
         end
         default:   c1NextState = C1_IDLE;
      endcase
      {c1HdrSel, c1DataSel} = c1Head[c1Gnt];
      if (c1Go) begin
         if (c1State == C1_IDLE) begin
            // A first beat announcing more lines pins the arbiter to this AFU.
            if (c1HdrSel.sop && c1HdrSel.cl_len != 2'd0) begin
               c1NextState = C1_LOCKED;
               beatsNext   = c1HdrSel.cl_len;
               lockNext    = c1Gnt;
            end
         end else begin
            beatsNext = beatsLeft - 1'b1;
            if (beatsLeft == 2'd1) c1NextState = C1_IDLE;
         end
      end
      c1Pop = '0;
      if (c1Go) c1Pop[c1Gnt] = 1'b1;
      c1Tagged = c1HdrSel;
      c1Tagged.mdata = tagMdata(c1HdrSel.mdata, c1Gnt);
   end

   // c1 state, lock bookkeeping and upstream register.
   always_ff @(posedge pClk or negedge SoftReset_n) begin
      if (!SoftReset_n) begin
         c1State   <= C1_IDLE;
         c1Ptr     <= '0;
         lockId    <= '0;
         beatsLeft <= '0;
         c1Out     <= '0;
      end else begin
         c1State   <= c1NextState;
         lockId    <= lockNext;
         beatsLeft <= beatsNext;
         if (c1Go) c1Ptr <= nextIdx(c1Gnt);
         c1Out.valid <= c1Go;
         c1Out.hdr   <= c1Go ? c1Tagged : '0;
         c1Out.data  <= c1Go ? c1DataSel : '0;
      end
   end

   // Upstream port: registered c0/c1, c2 unused and held at zero.
   always_comb begin
      up_TxPort    = '0;
      up_TxPort.c0 = c0Out;
      up_TxPort.c1 = c1Out;
   end
endmodule

// File: tb/tb_vai_tx_arb.sv
// Directed bench for vai_tx_arb with N=4: ordering, tagging, locked
// multi-line writes, backpressure, overflow, mid-burst reset and fairness.
module tb_vai_tx_arb;
   import vai_tx_pkg::*;

   logic        pClk, SoftReset_n;
   t_if_ccip_Tx afu [4];
   logic [3:0]  afuAlm0, afuAlm1, errOvf;
   logic        upAlm0, upAlm1;
   t_if_ccip_Tx up;

   int checks, errors;

   vai_tx_arb #(.NUM_SUB_AFUS(4), .FIFO_DEPTH(16), .ALMFULL_THR(8)) dut (
      .pClk(pClk), .SoftReset_n(SoftReset_n), .afu_TxPort(afu),
      .afu_c0AlmFull(afuAlm0), .afu_c1AlmFull(afuAlm1),
      .up_c0TxAlmFull(upAlm0), .up_c1TxAlmFull(upAlm1),
      .up_TxPort(up), .err_overflow(errOvf));

   initial pClk = 1'b0;
   always #5 pClk = ~pClk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pClk);
      #1;
   endtask

   task automatic idleAll();
      for (int i = 0; i < 4; i++) afu[i] = '0;
   endtask

   task automatic pushC0(input int i, input logic [41:0] addr, input logic [15:0] md);
      afu[i].c0.valid        = 1'b1;
      afu[i].c0.hdr          = '0;
      afu[i].c0.hdr.address  = addr;
      afu[i].c0.hdr.mdata    = md;
   endtask

   task automatic pushC1(input int i, input logic sop, input logic [1:0] len,
                         input logic [41:0] addr, input logic [15:0] md,
                         input logic [511:0] data);
      afu[i].c1.valid        = 1'b1;
      afu[i].c1.hdr          = '0;
      afu[i].c1.hdr.sop      = sop;
      afu[i].c1.hdr.cl_len   = len;
      afu[i].c1.hdr.address  = addr;
      afu[i].c1.hdr.mdata    = md;
      afu[i].c1.data         = data;
   endtask

   initial begin
      int nPush;
      int cnt [4];
      int rotErr;
      logic [1:0] id;
      checks = 0; errors = 0;
      idleAll(); upAlm0 = 1'b0; upAlm1 = 1'b0; SoftReset_n = 1'b0;
      tick(); tick();

      // Reset state.
      check("rst_c0_valid", 64'(up.c0.valid), 64'd0);
      check("rst_c1_valid", 64'(up.c1.valid), 64'd0);
      check("rst_c2", 64'(up.c2.mmioRdValid), 64'd0);
      check("rst_alm0", 64'(afuAlm0), 64'd0);
      check("rst_alm1", 64'(afuAlm1), 64'd0);
      check("rst_err", 64'(errOvf), 64'd0);
      SoftReset_n = 1'b1;
      tick(); tick();

      // Four simultaneous c0 reads: out on cycles 2..5 in order 0..3, tagged.
      for (int cyc = 0; cyc < 8; cyc++) begin
         idleAll();
         if (cyc == 0)
            for (int i = 0; i < 4; i++) pushC0(i, 42'(100 + i), {2'b11, 14'(i * 17)});
         if (cyc >= 2 && cyc <= 5) begin
            id = 2'(cyc - 2);
            check("rr_c0_valid", 64'(up.c0.valid), 64'd1);
            check("rr_c0_mdata", 64'(up.c0.hdr.mdata), 64'({id, 14'(int'(id) * 17)}));
            check("rr_c0_addr", 64'(up.c0.hdr.address), 64'(100 + int'(id)));
         end else
            check("rr_c0_idle", 64'(up.c0.valid), 64'd0);
         tick();
      end

      // AFU1 4-line write then AFU2 single write: no interleave.
      for (int cyc = 0; cyc < 9; cyc++) begin
         idleAll();
         if (cyc <= 3) pushC1(1, cyc == 0, 2'd3, 42'd200, 16'h0001, 512'(cyc));
         if (cyc == 1) pushC1(2, 1'b1, 2'd0, 42'd300, 16'h0002, 512'hAA);
         if (cyc >= 2 && cyc <= 5) begin
            check("lk_c1_valid", 64'(up.c1.valid), 64'd1);
            check("lk_c1_mdata", 64'(up.c1.hdr.mdata), 64'h4001);
            check("lk_c1_data", 64'(up.c1.data), 64'(cyc - 2));
         end else if (cyc == 6) begin
            check("lk_c1_valid2", 64'(up.c1.valid), 64'd1);
            check("lk_c1_mdata2", 64'(up.c1.hdr.mdata), 64'h8002);
            check("lk_c1_data2", 64'(up.c1.data), 64'hAA);
         end else
            check("lk_c1_idle", 64'(up.c1.valid), 64'd0);
         tick();
      end

      // Upstream c0 blocked: AFU0 obeys its almFull, which rises at cycle 9.
      upAlm0 = 1'b1; nPush = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         idleAll();
         check("bp_alm0", 64'(afuAlm0[0]), 64'(cyc >= 9));
         check("bp_c0_blocked", 64'(up.c0.valid), 64'd0);
         if (!afuAlm0[0]) begin
            pushC0(0, 42'(nPush), 16'(nPush));
            nPush++;
         end
         tick();
      end
      check("bp_npush", 64'(nPush), 64'd9);
      upAlm0 = 1'b0;
      for (int cyc = 20; cyc < 32; cyc++) begin
         idleAll();
         if (cyc >= 21 && cyc <= 29) begin
            check("bp_drain_valid", 64'(up.c0.valid), 64'd1);
            check("bp_drain_addr", 64'(up.c0.hdr.address), 64'(cyc - 21));
         end else if (cyc > 29)
            check("bp_drain_idle", 64'(up.c0.valid), 64'd0);
         tick();
      end

      // 17 pushes into a 16-deep FIFO while blocked: sticky overflow.
      upAlm0 = 1'b1;
      for (int cyc = 0; cyc < 18; cyc++) begin
         idleAll();
         if (cyc < 17) pushC0(0, 42'(cyc), 16'(cyc));
         if (cyc == 16) check("ovf_before", 64'(errOvf), 64'd0);
         if (cyc == 17) check("ovf_after", 64'(errOvf), 64'b0001);
         tick();
      end
      upAlm0 = 1'b0;
      for (int cyc = 18; cyc < 37; cyc++) begin
         idleAll();
         if (cyc >= 19 && cyc <= 34) begin
            check("ovf_drain_valid", 64'(up.c0.valid), 64'd1);
            check("ovf_drain_addr", 64'(up.c0.hdr.address), 64'(cyc - 19));
         end else if (cyc > 34)
            check("ovf_drain_idle", 64'(up.c0.valid), 64'd0);
         tick();
      end
      check("ovf_sticky", 64'(errOvf), 64'b0001);

      // Reset in the middle of AFU3's 4-line write.
      for (int cyc = 0; cyc < 4; cyc++) begin
         idleAll();
         pushC1(3, cyc == 0, 2'd3, 42'd400, 16'h0003, 512'(cyc));
         if (cyc >= 2) begin
            check("mr_c1_valid", 64'(up.c1.valid), 64'd1);
            check("mr_c1_mdata", 64'(up.c1.hdr.mdata), 64'hC003);
            check("mr_c1_data", 64'(up.c1.data), 64'(cyc - 2));
         end
         if (cyc < 3) tick();
      end
      idleAll();
      #2 SoftReset_n = 1'b0;
      #1;
      check("mr_async_c1", 64'(up.c1.valid), 64'd0);
      check("mr_async_err", 64'(errOvf), 64'd0);
      tick(); tick();
      SoftReset_n = 1'b1;
      for (int cyc = 0; cyc < 7; cyc++) begin
         idleAll();
         if (cyc == 1) pushC1(0, 1'b1, 2'd0, 42'd500, 16'h0000, 512'h55);
         if (cyc == 3) begin
            check("mr_post_valid", 64'(up.c1.valid), 64'd1);
            check("mr_post_mdata", 64'(up.c1.hdr.mdata), 64'h0000);
            check("mr_post_data", 64'(up.c1.data), 64'h55);
         end else
            check("mr_post_idle", 64'(up.c1.valid), 64'd0);
         tick();
      end

      // Saturate c0 from all four AFUs: strict rotation, 100 grants each.
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      rotErr = 0;
      for (int cyc = 0; cyc < 404; cyc++) begin
         idleAll();
         if (cyc <= 401)
            for (int i = 0; i < 4; i++)
               if (!afuAlm0[i]) pushC0(i, 42'(cyc), 16'(i));
         if (cyc >= 2 && cyc <= 401) begin
            if (up.c0.valid) begin
               id = up.c0.hdr.mdata[15:14];
               cnt[id]++;
               if (int'(id) != (cyc - 2) % 4) rotErr++;
               if (up.c0.hdr.mdata[13:0] != 14'(id)) rotErr++;
            end else
               rotErr++;
         end
         tick();
      end
      for (int i = 0; i < 4; i++) check($sformatf("sat_cnt%0d", i), 64'(cnt[i]), 64'd100);
      check("sat_rotation", 64'(rotErr), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
